// File: rtl/alu_seq_unit.sv
// Clocked ALU: single-cycle logic/add/sub ops plus iterative shift-add multiply
// and restoring divide, with a start/busy/done handshake and registered flags.
module alu_seq_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_dz
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned ACC_W = 2 * WIDTH;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_DIV = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIN  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   result_hi_q, result_hi_d;
  logic               flag_z_q, flag_z_d;
  logic               flag_c_q, flag_c_d;
  logic               flag_dz_q, flag_dz_d;

  logic [WIDTH:0]     add_w, sub_w;
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic [ACC_W-1:0]   mul_next, div_next;
  logic               alu_wr;
  logic [WIDTH-1:0]   alu_res, alu_hi;
  logic               alu_c, alu_dz;

  assign add_w = {1'b0, a} + {1'b0, b};
  assign sub_w = {1'b0, a} - {1'b0, b};

  // Multiply: acc = {partial_hi, multiplier}; add multiplicand when LSB set, then shift right.
  assign mul_sum  = {1'b0, acc_q[ACC_W-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : (WIDTH + 1)'(0));
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend/quotient}; shift left, subtract divisor if it fits.
  assign div_sh   = {acc_q[ACC_W-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opnd_q};
  assign div_next = div_diff[WIDTH] ? {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    opnd_d      = opnd_q;
    is_div_d    = is_div_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    flag_z_d    = flag_z_q;
    flag_c_d    = flag_c_q;
    flag_dz_d   = flag_dz_q;
    alu_wr      = 1'b0;
    alu_res     = '0;
    alu_hi      = '0;
    alu_c       = 1'b0;
    alu_dz      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          unique case (op)
            OP_ADD: begin alu_wr = 1'b1; alu_res = add_w[WIDTH-1:0]; alu_c = add_w[WIDTH]; end
            OP_SUB: begin alu_wr = 1'b1; alu_res = sub_w[WIDTH-1:0]; alu_c = sub_w[WIDTH]; end
            OP_AND: begin alu_wr = 1'b1; alu_res = a & b; end
            OP_OR:  begin alu_wr = 1'b1; alu_res = a | b; end
            OP_XOR: begin alu_wr = 1'b1; alu_res = a ^ b; end
            OP_NOT: begin alu_wr = 1'b1; alu_res = ~a; end
            OP_MUL: begin
              acc_d    = {WIDTH'(0), b};
              opnd_d   = a;
              is_div_d = 1'b0;
              cnt_d    = CNT_W'(WIDTH);
              busy_d   = 1'b1;
              state_d  = ITER;
            end
            OP_DIV: begin
              if (b == '0) begin
                // Divide by zero completes immediately with a saturated quotient.
                alu_wr  = 1'b1;
                alu_res = '1;
                alu_hi  = a;
                alu_dz  = 1'b1;
              end else begin
                acc_d    = {WIDTH'(0), a};
                opnd_d   = b;
                is_div_d = 1'b1;
                cnt_d    = CNT_W'(WIDTH);
                busy_d   = 1'b1;
                state_d  = ITER;
              end
            end
            default: ;
          endcase
        end
      end
      ITER: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = FIN;
      end
      FIN: begin
        result_d    = acc_q[WIDTH-1:0];
        result_hi_d = acc_q[ACC_W-1:WIDTH];
        flag_z_d    = (acc_q[WIDTH-1:0] == '0);
        flag_c_d    = !is_div_q && (acc_q[ACC_W-1:WIDTH] != '0);
        flag_dz_d   = 1'b0;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (alu_wr) begin
      result_d    = alu_res;
      result_hi_d = alu_hi;
      flag_z_d    = (alu_res == '0) && !alu_dz;
      flag_c_d    = alu_c;
      flag_dz_d   = alu_dz;
      done_d      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      opnd_q      <= '0;
      is_div_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      flag_z_q    <= 1'b0;
      flag_c_q    <= 1'b0;
      flag_dz_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      opnd_q      <= opnd_d;
      is_div_q    <= is_div_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      flag_z_q    <= flag_z_d;
      flag_c_q    <= flag_c_d;
      flag_dz_q   <= flag_dz_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign flag_z    = flag_z_q;
  assign flag_c    = flag_c_q;
  assign flag_dz   = flag_dz_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit at WIDTH=8, plus random sweeps at WIDTH=4 and 16.
module tb_alu_seq_unit;

  logic clk, rst_n;
  int   errors, checks;

  logic       start;
  logic [2:0] op;
  logic [7:0] a, b, result, result_hi;
  logic       busy, done, flag_z, flag_c, flag_dz;

  logic       s4_start, s4_busy, s4_done, s4_z, s4_c, s4_dz;
  logic [2:0] s4_op;
  logic [3:0] s4_a, s4_b, s4_result, s4_result_hi;

  logic        s16_start, s16_busy, s16_done, s16_z, s16_c, s16_dz;
  logic [2:0]  s16_op;
  logic [15:0] s16_a, s16_b, s16_result, s16_result_hi;

  alu_seq_unit #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .result_hi(result_hi),
    .flag_z(flag_z), .flag_c(flag_c), .flag_dz(flag_dz));

  alu_seq_unit #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(s4_start), .op(s4_op), .a(s4_a), .b(s4_b),
    .busy(s4_busy), .done(s4_done), .result(s4_result), .result_hi(s4_result_hi),
    .flag_z(s4_z), .flag_c(s4_c), .flag_dz(s4_dz));

  alu_seq_unit #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(s16_start), .op(s16_op), .a(s16_a), .b(s16_b),
    .busy(s16_busy), .done(s16_done), .result(s16_result), .result_hi(s16_result_hi),
    .flag_z(s16_z), .flag_c(s16_c), .flag_dz(s16_dz));

  always #5 clk = ~clk;

  // {op, a, b, result, result_hi, {z,c,dz}}
  localparam logic [37:0] ALU_VEC [8] = '{
    {3'd0, 8'hF0, 8'h20, 8'h10, 8'h00, 3'b010},
    {3'd1, 8'h05, 8'h05, 8'h00, 8'h00, 3'b100},
    {3'd1, 8'h03, 8'h05, 8'hFE, 8'h00, 3'b010},
    {3'd5, 8'h0F, 8'hAA, 8'hF0, 8'h00, 3'b000},
    {3'd2, 8'hCA, 8'h0F, 8'h0A, 8'h00, 3'b000},
    {3'd3, 8'hC0, 8'h0A, 8'hCA, 8'h00, 3'b000},
    {3'd4, 8'hFF, 8'hFF, 8'h00, 8'h00, 3'b100},
    {3'd0, 8'h7F, 8'h01, 8'h80, 8'h00, 3'b000}
  };

  localparam logic [37:0] MD_VEC [7] = '{
    {3'd6, 8'hFF, 8'hFF, 8'h01, 8'hFE, 3'b010},
    {3'd6, 8'h07, 8'h06, 8'h2A, 8'h00, 3'b000},
    {3'd6, 8'h00, 8'h9A, 8'h00, 8'h00, 3'b100},
    {3'd7, 8'hC8, 8'h07, 8'h1C, 8'h04, 3'b000},
    {3'd7, 8'h05, 8'h09, 8'h00, 8'h05, 3'b100},
    {3'd7, 8'h37, 8'h00, 8'hFF, 8'h37, 3'b001},
    {3'd7, 8'hFF, 8'h01, 8'hFF, 8'h00, 3'b000}
  };

  // Issue one op at a negedge and return at the negedge where done is seen.
  task automatic run_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                        output int lat, output int nbusy);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = ~o; a = ~x; b = ~y;
    lat = 1; nbusy = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) nbusy++;
      @(negedge clk);
      lat++;
    end
  endtask

  function automatic void model(input int w, input logic [2:0] o, input logic [63:0] x,
                                input logic [63:0] y, output logic [63:0] r,
                                output logic [63:0] h, output logic z, output logic c,
                                output logic dz);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    h = '0; c = 1'b0; dz = 1'b0;
    case (o)
      3'd0: begin r = (x + y) & m; c = ((x + y) >> w) != 0; end
      3'd1: begin r = (x - y) & m; c = x < y; end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: r = ~x & m;
      3'd6: begin r = (x * y) & m; h = (x * y) >> w; c = h != 0; end
      default: begin
        if (y == 0) begin r = m; h = x; dz = 1'b1; end
        else begin r = x / y; h = x % y; end
      end
    endcase
    z = (r == 0) && !dz;
  endfunction

  task automatic test_reset();
    int lat, nb;
    bit seen;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({busy, done, result, result_hi, flag_z, flag_c, flag_dz} !== 21'd0) begin
      errors++;
      $display("FAIL reset_hold outputs=%h required 0",
               {busy, done, result, result_hi, flag_z, flag_c, flag_dz});
    end
    rst_n = 1'b1;
    @(negedge clk);
    run_op(3'd0, 8'h12, 8'h34, lat, nb);
    checks++;
    if (result !== 8'h46) begin
      errors++; $display("FAIL pre_reset_add result=%h required 46", result);
    end
    op = 3'd6; a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, result, result_hi, flag_z, flag_c, flag_dz} !== 21'd0) begin
      errors++;
      $display("FAIL reset_async outputs=%h required 0",
               {busy, done, result, result_hi, flag_z, flag_c, flag_dz});
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL reset_abort busy/done seen after release=%b required 0", seen);
    end
    checks++;
    if ({result, result_hi, flag_z, flag_c, flag_dz} !== 19'd0) begin
      errors++;
      $display("FAIL reset_after outputs=%h required 0",
               {result, result_hi, flag_z, flag_c, flag_dz});
    end
  endtask

  task automatic test_alu_ops();
    logic [37:0] v;
    int lat, nb;
    for (int i = 0; i < 8; i++) begin
      v = ALU_VEC[i];
      run_op(v[37:35], v[34:27], v[26:19], lat, nb);
      checks++;
      if ({result, result_hi, flag_z, flag_c, flag_dz} !== v[18:0] || lat != 1) begin
        errors++;
        $display("FAIL alu_op[%0d] res=%h hi=%h zcd=%b lat=%0d required res=%h hi=%h zcd=%b lat=1",
                 i, result, result_hi, {flag_z, flag_c, flag_dz}, lat, v[18:11], v[10:3], v[2:0]);
      end
    end
  endtask

  task automatic test_muldiv();
    logic [37:0] v;
    int lat, nb, elat, enb;
    for (int i = 0; i < 7; i++) begin
      v = MD_VEC[i];
      elat = (v[37:35] == 3'd7 && v[26:19] == 8'h00) ? 1 : 10;
      enb  = (elat == 10) ? 9 : 0;
      run_op(v[37:35], v[34:27], v[26:19], lat, nb);
      checks++;
      if ({result, result_hi, flag_z, flag_c, flag_dz} !== v[18:0]) begin
        errors++;
        $display("FAIL muldiv_val[%0d] res=%h hi=%h zcd=%b required res=%h hi=%h zcd=%b",
                 i, result, result_hi, {flag_z, flag_c, flag_dz}, v[18:11], v[10:3], v[2:0]);
      end
      checks++;
      if (lat != elat || nb != enb || busy !== 1'b0) begin
        errors++;
        $display("FAIL muldiv_timing[%0d] lat=%0d busy_cycles=%0d busy=%b required %0d %0d 0",
                 i, lat, nb, busy, elat, enb);
      end
    end
  endtask

  task automatic test_handshake();
    int guard;
    bit seen;
    op = 3'd6; a = 8'h07; b = 8'h06; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); op = 3'd0; a = 8'h01; b = 8'h01; start = 1'b1;
    @(negedge clk); start = 1'b0;
    guard = 0;
    while (done !== 1'b1 && guard < 40) begin @(negedge clk); guard++; end
    checks++;
    if ({done, result, result_hi, flag_c} !== {1'b1, 8'h2A, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL ignored_start done=%b res=%h hi=%h c=%b required 1 2a 00 0",
               done, result, result_hi, flag_c);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || result !== 8'h2A) begin
      errors++;
      $display("FAIL ignored_no_extra done=%b res=%h required 0 2a", done, result);
    end
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen || {result, result_hi, flag_z, flag_c, flag_dz} !== {8'h2A, 8'h00, 3'b000}) begin
      errors++;
      $display("FAIL hold done_seen=%b res=%h hi=%h zcd=%b required 0 2a 00 000",
               seen, result, result_hi, {flag_z, flag_c, flag_dz});
    end
  endtask

  task automatic test_back_to_back();
    int lat, nb;
    run_op(3'd6, 8'hFF, 8'hFF, lat, nb);
    run_op(3'd0, 8'h01, 8'h02, lat, nb);
    checks++;
    if (lat != 1 || {result, result_hi, flag_z, flag_c, flag_dz} !== {8'h03, 8'h00, 3'b000}) begin
      errors++;
      $display("FAIL start_in_done lat=%0d res=%h hi=%h zcd=%b required 1 03 00 000",
               lat, result, result_hi, {flag_z, flag_c, flag_dz});
    end
    run_op(3'd7, 8'h37, 8'h00, lat, nb);
    run_op(3'd0, 8'h01, 8'h01, lat, nb);
    checks++;
    if (lat != 1 || {result, result_hi, flag_z, flag_c, flag_dz} !== {8'h02, 8'h00, 3'b000}) begin
      errors++;
      $display("FAIL after_divzero lat=%0d res=%h hi=%h zcd=%b required 1 02 00 000",
               lat, result, result_hi, {flag_z, flag_c, flag_dz});
    end
  endtask

  task automatic test_sweep_w4();
    logic [63:0] er, eh;
    logic ez, ec, edz;
    int lat, nb;
    for (int i = 0; i < 1000; i++) begin
      s4_op = 3'($urandom_range(0, 7)); s4_a = 4'($urandom); s4_b = 4'($urandom);
      s4_start = 1'b1;
      model(4, s4_op, 64'(s4_a), 64'(s4_b), er, eh, ez, ec, edz);
      @(negedge clk);
      s4_start = 1'b0; s4_a = 4'($urandom); s4_b = 4'($urandom);
      lat = 1; nb = 0;
      while (s4_done !== 1'b1 && lat < 60) begin
        if (s4_busy === 1'b1) nb++;
        @(negedge clk); lat++;
      end
      checks++;
      if ({s4_result, s4_result_hi, s4_z, s4_c, s4_dz} !== {er[3:0], eh[3:0], ez, ec, edz}) begin
        errors++;
        $display("FAIL w4_op[%0d] res=%h hi=%h zcd=%b required %h %h %b",
                 i, s4_result, s4_result_hi, {s4_z, s4_c, s4_dz}, er[3:0], eh[3:0], {ez, ec, edz});
      end
      if (nb != 0 || lat != 1) begin
        checks++;
        if (nb != 5 || edz) begin
          errors++; $display("FAIL w4_busy[%0d] busy_cycles=%0d required 5", i, nb);
        end
      end
    end
  endtask

  task automatic test_sweep_w16();
    logic [63:0] er, eh;
    logic ez, ec, edz;
    int lat, nb;
    for (int i = 0; i < 1000; i++) begin
      s16_op = 3'($urandom_range(0, 7)); s16_a = 16'($urandom);
      s16_b = (i % 50 == 0) ? 16'h0000 : 16'($urandom >> $urandom_range(0, 15));
      s16_start = 1'b1;
      model(16, s16_op, 64'(s16_a), 64'(s16_b), er, eh, ez, ec, edz);
      @(negedge clk);
      s16_start = 1'b0; s16_a = 16'($urandom); s16_b = 16'($urandom);
      lat = 1; nb = 0;
      while (s16_done !== 1'b1 && lat < 80) begin
        if (s16_busy === 1'b1) nb++;
        @(negedge clk); lat++;
      end
      checks++;
      if ({s16_result, s16_result_hi, s16_z, s16_c, s16_dz} !== {er[15:0], eh[15:0], ez, ec, edz}) begin
        errors++;
        $display("FAIL w16_op[%0d] res=%h hi=%h zcd=%b required %h %h %b",
                 i, s16_result, s16_result_hi, {s16_z, s16_c, s16_dz}, er[15:0], eh[15:0], {ez, ec, edz});
      end
      if (nb != 0 || lat != 1) begin
        checks++;
        if (nb != 17 || edz) begin
          errors++; $display("FAIL w16_busy[%0d] busy_cycles=%0d required 17", i, nb);
        end
      end
    end
  endtask

  initial begin
    errors = 0; checks = 0;
    clk = 1'b0; rst_n = 1'b0;
    start = 1'b0; op = '0; a = '0; b = '0;
    s4_start = 1'b0; s4_op = '0; s4_a = '0; s4_b = '0;
    s16_start = 1'b0; s16_op = '0; s16_a = '0; s16_b = '0;
    test_reset();
    test_alu_ops();
    test_muldiv();
    test_handshake();
    test_back_to_back();
    test_sweep_w4();
    test_sweep_w16();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
